// File: rtl/div_seq_pkg.sv
// Shared defines for the sequential divider.
// Also pulled in by the EX stage for result handshaking.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_ON      = 2'b01,
    DIV_END     = 2'b10,
    DIV_SPECIAL = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_lzc.sv
// Leading-zero counter for the early-out path.
// Returns W when the input is all zeros.
module div_lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]             a_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);

  localparam int CW = $clog2(W+1);

  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (a_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
// Shifts the next dividend bit in, subtracts when it fits.
module div_step #(
  parameter int W = 33
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W-1:0] sh;

  always_comb begin
    sh    = (rem_i << 1) | W'(bit_i);
    q_o   = (sh >= dvs_i);
    rem_o = q_o ? (sh - dvs_i) : sh;
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, signed and unsigned.
// Result is {remainder, quotient}, held while start_i stays high.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 div_zero_o
);

  localparam int CW = $clog2(WIDTH+1);

  div_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               sq_q, sq_d;
  logic               sr_q, sr_d;
  logic               zf_q, zf_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rdy_q, rdy_d;
  logic               dz_q, dz_d;

  logic               take, is_zero, is_ovf;
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [CW-1:0]      lz;
  logic [WIDTH:0]     step_rem;
  logic               step_q;
  logic               done;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               clr;

  assign take    = start_i & ~annul_i;
  assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign mag1    = op1_neg ? -opdata1_i : opdata1_i;
  assign mag2    = op2_neg ? -opdata2_i : opdata2_i;
  assign is_zero = (opdata2_i == '0);
  assign is_ovf  = signed_div_i
                 & (opdata1_i == {1'b1, {(WIDTH-1){1'b0}}})
                 & (opdata2_i == '1);
  assign done    = (cnt_q == CW'(WIDTH));
  assign q_fix   = sq_q ? -dvd_q : dvd_q;
  assign r_fix   = sr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  generate
    if (EARLY_OUT) begin : g_lzc
      div_lzc #(.W(WIDTH)) u_lzc (
        .a_i   (mag1),
        .cnt_o (lz)
      );
    end else begin : g_no_lzc
      assign lz = '0;
    end
  endgenerate

  div_step #(.W(WIDTH+1)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[WIDTH-1]),
    .dvs_i ({1'b0, dvs_q}),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DIV_FREE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      zf_q    <= 1'b0;
      res_q   <= '0;
      rdy_q   <= DivResultNotReady;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      zf_q    <= zf_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_FREE: begin
        if (take) state_d = (is_zero | is_ovf) ? DIV_SPECIAL : DIV_ON;
      end
      DIV_ON: begin
        if (annul_i)   state_d = DIV_FREE;
        else if (done) state_d = DIV_END;
      end
      DIV_END, DIV_SPECIAL: begin
        if (!start_i) state_d = DIV_FREE;
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    rem_d = rem_q;
    sq_d  = sq_q;
    sr_d  = sr_q;
    zf_d  = zf_q;
    res_d = res_q;
    rdy_d = rdy_q;
    dz_d  = dz_q;
    clr   = 1'b0;
    unique case (state_q)
      DIV_FREE: begin
        if (take) begin
          sq_d = 1'b0;
          sr_d = 1'b0;
          zf_d = 1'b0;
          unique case (1'b1)
            is_zero: begin
              dvd_d = '1;
              rem_d = {1'b0, opdata1_i};
              zf_d  = 1'b1;
            end
            is_ovf: begin
              dvd_d = opdata1_i;
              rem_d = '0;
            end
            default: begin
              // leading zeros of the magnitude yield zero quotient bits
              cnt_d = lz;
              dvd_d = mag1 << lz;
              dvs_d = mag2;
              rem_d = '0;
              sq_d  = op1_neg ^ op2_neg;
              sr_d  = op1_neg;
            end
          endcase
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          clr = 1'b1;
        end else if (!done) begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV_END, DIV_SPECIAL: begin
        if (start_i) begin
          res_d = {r_fix, q_fix};
          rdy_d = DivResultReady;
          dz_d  = zf_q;
        end else begin
          clr = 1'b1;
        end
      end
      default: clr = 1'b1;
    endcase
    if (clr) begin
      cnt_d = '0;
      dvd_d = '0;
      dvs_d = '0;
      rem_d = '0;
      sq_d  = 1'b0;
      sr_d  = 1'b0;
      zf_d  = 1'b0;
      res_d = '0;
      rdy_d = DivResultNotReady;
      dz_d  = 1'b0;
    end
  end

  assign result_o   = res_q;
  assign ready_o    = rdy_q;
  assign busy_o     = (state_q == DIV_ON);
  assign div_zero_o = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at several widths and early-out settings.
// Reference results come from plain integer division.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        sg;
  logic [63:0] a, b;
  logic [4:0]  st, an, rdy, bsy, dz;
  logic [63:0] r0, r1;
  logic [31:0] r2, r3;
  logic [15:0] r4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32), .EARLY_OUT(1'b0)) u0 (
    .clk(clk), .rst(rst), .signed_div_i(sg),
    .opdata1_i(a[31:0]), .opdata2_i(b[31:0]),
    .start_i(st[0]), .annul_i(an[0]), .result_o(r0),
    .ready_o(rdy[0]), .busy_o(bsy[0]), .div_zero_o(dz[0]));

  div_seq #(.WIDTH(32), .EARLY_OUT(1'b1)) u1 (
    .clk(clk), .rst(rst), .signed_div_i(sg),
    .opdata1_i(a[31:0]), .opdata2_i(b[31:0]),
    .start_i(st[1]), .annul_i(an[1]), .result_o(r1),
    .ready_o(rdy[1]), .busy_o(bsy[1]), .div_zero_o(dz[1]));

  div_seq #(.WIDTH(16), .EARLY_OUT(1'b0)) u2 (
    .clk(clk), .rst(rst), .signed_div_i(sg),
    .opdata1_i(a[15:0]), .opdata2_i(b[15:0]),
    .start_i(st[2]), .annul_i(an[2]), .result_o(r2),
    .ready_o(rdy[2]), .busy_o(bsy[2]), .div_zero_o(dz[2]));

  div_seq #(.WIDTH(16), .EARLY_OUT(1'b1)) u3 (
    .clk(clk), .rst(rst), .signed_div_i(sg),
    .opdata1_i(a[15:0]), .opdata2_i(b[15:0]),
    .start_i(st[3]), .annul_i(an[3]), .result_o(r3),
    .ready_o(rdy[3]), .busy_o(bsy[3]), .div_zero_o(dz[3]));

  div_seq #(.WIDTH(8), .EARLY_OUT(1'b0)) u4 (
    .clk(clk), .rst(rst), .signed_div_i(sg),
    .opdata1_i(a[7:0]), .opdata2_i(b[7:0]),
    .start_i(st[4]), .annul_i(an[4]), .result_o(r4),
    .ready_o(rdy[4]), .busy_o(bsy[4]), .div_zero_o(dz[4]));

  function automatic int wof(input int k);
    case (k)
      0, 1:    return 32;
      2, 3:    return 16;
      default: return 8;
    endcase
  endfunction

  function automatic bit eof(input int k);
    return (k == 1) || (k == 3);
  endfunction

  function automatic logic [127:0] ores(input int k);
    case (k)
      0:       return 128'(r0);
      1:       return 128'(r1);
      2:       return 128'(r2);
      3:       return 128'(r3);
      default: return 128'(r4);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] o,
                     input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic void model(input int w, input logic s,
                                input logic [63:0] x0, y0, input bit eo,
                                output logic [127:0] res,
                                output logic dzo, output int lat);
    logic [63:0] m, x, y, q, r, mag;
    longint sx, sy;
    int lz;
    m   = (64'd1 << w) - 64'd1;
    x   = x0 & m;
    y   = y0 & m;
    dzo = 1'b0;
    sx  = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
    sy  = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
    if (y == 64'd0) begin
      q = m; r = x; dzo = 1'b1; lat = 1;
    end else if (s && sx == -(longint'(1) << (w-1)) && sy == -1) begin
      q = x; r = 64'd0; lat = 1;
    end else begin
      if (s) begin
        q   = 64'(sx / sy);
        r   = 64'(sx % sy);
        mag = (sx < 0) ? 64'(-sx) : x;
      end else begin
        q   = x / y;
        r   = x % y;
        mag = x;
      end
      lz = 0;
      for (int i = w - 1; i >= 0; i--) begin
        if (mag[i]) break;
        lz++;
      end
      lat = w + 2 - (eo ? lz : 0);
    end
    res = (128'(r & m) << w) | 128'(q & m);
  endfunction

  task automatic run_op(input int k, input logic s,
                        input logic [63:0] x, y, input int hold,
                        input bit drop, output logic [127:0] got,
                        output int lat);
    logic [127:0] er;
    logic ed;
    int el;
    int n;
    bit seen;
    model(wof(k), s, x, y, eof(k), er, ed, el);
    sg = s; a = x; b = y; st[k] = 1'b1;
    seen = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        chk("busy_after_start", 128'(bsy[k]), 128'(el != 1));
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        sg = 1'($urandom);
      end
      if (rdy[k]) begin
        seen = 1'b1;
        break;
      end
    end
    lat = seen ? n - 1 : -1;
    chk("latency", 128'(lat), 128'(el));
    chk("result", ores(k), er);
    chk("div_zero", 128'(dz[k]), 128'(ed));
    got = ores(k);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_ready", 128'(rdy[k]), 128'(1));
      chk("hold_result", ores(k), er);
      chk("hold_div_zero", 128'(dz[k]), 128'(ed));
    end
    if (drop) begin
      st[k] = 1'b0;
      @(posedge clk); #1;
      chk("drop_ready", 128'(rdy[k]), 128'(0));
      chk("drop_result", ores(k), 128'(0));
      chk("drop_div_zero", 128'(dz[k]), 128'(0));
      chk("drop_busy", 128'(bsy[k]), 128'(0));
    end
  endtask

  initial begin
    logic [127:0] got;
    int lat;
    int k, w, mode;
    logic s;
    logic [63:0] x, y;

    rst = 1'b0; sg = 1'b0; a = '0; b = '0; st = '0; an = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("reset_result", ores(i), 128'(0));
    end
    chk("reset_flags", 128'({rdy, bsy, dz}), 128'(0));
    rst = 1'b1;

    run_op(0, 1'b0, 64'd100, 64'd7, 2, 1'b1, got, lat);
    chk("u100_7", got, 128'({32'h2, 32'hE}));
    chk("u100_7_lat", 128'(lat), 128'(34));

    run_op(1, 1'b1, 64'(32'hFFFFFF9C), 64'd7, 1, 1'b1, got, lat);
    chk("sneg100_7", got, 128'({32'hFFFFFFFE, 32'hFFFFFFF2}));

    run_op(0, 1'b1, 64'd100, 64'(32'hFFFFFFF9), 0, 1'b1, got, lat);
    chk("s100_neg7", got, 128'({32'h00000002, 32'hFFFFFFF2}));

    run_op(0, 1'b0, 64'd5, 64'd0, 2, 1'b1, got, lat);
    chk("div0", got, 128'({32'h5, 32'hFFFFFFFF}));
    chk("div0_lat", 128'(lat), 128'(1));

    run_op(1, 1'b1, 64'(32'h80000000), 64'(32'hFFFFFFFF), 1, 1'b1, got, lat);
    chk("ovf", got, 128'({32'h0, 32'h80000000}));

    // abort in the tenth busy cycle
    sg = 1'b0; a = 64'd1000; b = 64'd3; st[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("annul_no_ready", 128'(rdy[0]), 128'(0));
    end
    an[0] = 1'b1; st[0] = 1'b0;
    @(posedge clk); #1;
    an[0] = 1'b0;
    chk("annul_busy", 128'(bsy[0]), 128'(0));
    chk("annul_ready", 128'(rdy[0]), 128'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("annul_quiet", 128'({rdy[0], bsy[0]}), 128'(0));
    end
    run_op(0, 1'b0, 64'd9, 64'd3, 0, 1'b1, got, lat);
    chk("after_annul", got, 128'({32'h0, 32'h3}));

    // annul while idle blocks the start for that edge
    sg = 1'b0; a = 64'd50; b = 64'd5; st[2] = 1'b1; an[2] = 1'b1;
    @(posedge clk); #1;
    chk("annul_free_busy", 128'(bsy[2]), 128'(0));
    an[2] = 1'b0;
    run_op(2, 1'b0, 64'd50, 64'd5, 0, 1'b1, got, lat);

    // async reset while the result is presented
    run_op(4, 1'b0, 64'd200, 64'd3, 1, 1'b0, got, lat);
    #3 rst = 1'b0;
    #1;
    chk("rst_end_result", ores(4), 128'(0));
    chk("rst_end_flags", 128'({rdy[4], bsy[4], dz[4]}), 128'(0));
    st[4] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // async reset in the middle of iterating
    sg = 1'b0; a = 64'd200; b = 64'd3; st[4] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_on_busy", 128'(bsy[4]), 128'(1));
    #3 rst = 1'b0;
    #1;
    chk("rst_on_busy", 128'(bsy[4]), 128'(0));
    chk("rst_on_out", 128'({rdy[4], dz[4], r4}), 128'(0));
    st[4] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    run_op(4, 1'b0, 64'd255, 64'd16, 1, 1'b1, got, lat);
    chk("u255_16", got, 128'(16'h0F0F));
    chk("u255_16_lat", 128'(lat), 128'(10));

    for (int it = 0; it < 48; it++) begin
      k = $urandom_range(0, 3);
      w = wof(k);
      s = 1'($urandom);
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      case (mode)
        0: y = 64'd0;
        1: x = x & ((64'd1 << $urandom_range(0, w)) - 64'd1);
        2: begin
          s = 1'b1;
          x = 64'd1 << (w - 1);
          y = '1;
        end
        3: y = 64'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(k, s, x, y, $urandom_range(0, 3), 1'b1, got, lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits; legal values are 8 to 64.
REQ-002 Parameter EARLY_OUT, default 0: 1 enables skipping the dividend's leading-zero iterations.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 signed_div_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-006 opdata1_i  input  WIDTH  dividend; sampled with start_i.
REQ-007 opdata2_i  input  WIDTH  divisor; sampled with start_i.
REQ-008 start_i  input  1  request; held high by the requester until ready_o is seen.
REQ-009 annul_i  input  1  abort of the operation in flight.
REQ-010 result_o  output  2*WIDTH  {remainder, quotient}; remainder occupies the upper half.
REQ-011 ready_o  output  1  result_o is valid.
REQ-012 busy_o  output  1  an iteration is in progress.
REQ-013 div_zero_o  output  1  the current result came from a zero divisor; qualified by ready_o.

Function
REQ-014 The FSM SHALL have four states: FREE, ON, END, SPECIAL.
REQ-015 FREE, start_i=1 and annul_i=0, divisor=0: go to SPECIAL with quotient all-ones, remainder = dividend, div_zero_o=1.
REQ-016 FREE, start_i=1, signed_div_i=1, dividend = most-negative value, divisor = all-ones: go to SPECIAL with quotient = most-negative value, remainder = 0.
REQ-017 FREE, start_i=1, any other operands: latch operand magnitudes and operand signs, clear the iteration counter, go to ON.
REQ-018 ON: perform one restoring shift-subtract step per cycle, WIDTH steps in total, then go to END.
REQ-019 END: apply the sign correction; quotient is negated when operand signs differ, remainder takes the dividend's sign.
REQ-020 Latency with EARLY_OUT=0: ready_o SHALL rise exactly WIDTH+2 rising edges after the edge that sampled start_i.
REQ-021 EARLY_OUT=1: skipped iterations SHALL equal the dividend magnitude's leading-zero count; the result SHALL be identical to the EARLY_OUT=0 result.
REQ-022 SPECIAL: ready_o SHALL rise 1 edge after the sampling edge.
REQ-023 ready_o, result_o and div_zero_o SHALL stay stable while start_i remains high in END or SPECIAL.
REQ-024 The first edge with start_i=0 in END or SPECIAL SHALL return the FSM to FREE and clear ready_o, result_o and div_zero_o to 0.
REQ-025 annul_i=1 in ON SHALL return the FSM to FREE on the next edge with no ready_o pulse; annul_i has priority over a step.
REQ-026 annul_i=1 in FREE SHALL suppress start_i for that cycle.
REQ-027 annul_i SHALL be ignored in END and SPECIAL.
REQ-028 Operand inputs and start_i SHALL be ignored while the FSM is not in FREE.
REQ-029 busy_o SHALL equal 1 only in state ON.
REQ-030 The internal partial remainder SHALL be WIDTH+1 bits wide.
REQ-031 Negation SHALL be two's-complement modulo 2^WIDTH.

Reset
REQ-032 rst=0 SHALL immediately force FREE and clear result_o, ready_o, busy_o, div_zero_o, the counter and all operand registers, including mid-operation.
REQ-033 Release of rst SHALL cause no ready_o pulse; the first start_i SHALL be sampled on the first rising edge with rst=1.

Structure
REQ-034 The state encodings DIV_FREE, DIV_ON, DIV_END and DIV_SPECIAL (2 bits) SHALL live in the shared defines package.
REQ-035 The shared package SHALL also hold the DivResultReady and DivResultNotReady constants, reused by the EX stage.
REQ-036 One combinational sub-module, div_step, SHALL compute one shift-subtract step (partial remainder, quotient bit) at width WIDTH+1.
REQ-037 A leading-zero counter SHALL be instantiated only when EARLY_OUT=1.

Verification
REQ-038 WIDTH=32, unsigned 100/7: result_o = {0x00000002, 0x0000000E}, ready_o rises 34 edges after start.
REQ-039 WIDTH=32, signed -100/7: quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; signed 100/-7: quotient 0xFFFFFFF2, remainder 0x00000002.
REQ-040 WIDTH=32, 5/0 unsigned: quotient 0xFFFFFFFF, remainder 5, div_zero_o=1, ready_o after 1 edge; signed 0x80000000/0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-041 annul_i pulsed in the 10th ON cycle: no ready_o, busy_o=0 next cycle; then 9/3: quotient 3, remainder 0, correct latency.
REQ-042 rst asserted mid-ON: all outputs 0 without waiting for a clock edge; after release, 255/16 with WIDTH=8: result_o = {0x0F, 0x0F}, ready_o after 10 edges.
REQ-043 Random signed and unsigned operands at WIDTH=32 and WIDTH=16, with EARLY_OUT=0 and EARLY_OUT=1: results SHALL match a reference model; start_i held through END and dropped at random, checking REQ-023 and REQ-024.
